// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: pipeline hazard controller with forwarding select, memory-wait freeze, halt latch and perf counters
module hazard_fwd_ctrl #(
   parameter int RW     = 5,
   parameter bit FWD_EN = 1'b1,
   parameter int CNTW   = 32
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            ihit,
   input  logic            dhit,
   input  logic            mem_req,
   input  logic [RW-1:0]   rs_id,
   input  logic [RW-1:0]   rt_id,
   input  logic [RW-1:0]   rs_ex,
   input  logic [RW-1:0]   rt_ex,
   input  logic [RW-1:0]   ex_dest,
   input  logic            ex_wen,
   input  logic            ex_memread,
   input  logic [RW-1:0]   mem_dest,
   input  logic            mem_wen,
   input  logic [RW-1:0]   wb_dest,
   input  logic            wb_wen,
   input  logic            br_mispred,
   input  logic            halt_mem,
   output logic            stall_pc,
   output logic            stall_ifid,
   output logic            flush_ifid,
   output logic            flush_idex,
   output logic            flush_exmem,
   output logic            pipe_en,
   output logic [1:0]      fwdA,
   output logic [1:0]      fwdB,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] flush_cnt
);
   typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;
   localparam logic [CNTW-1:0] ONE = CNTW'(1);
   state_t state_q, state_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic freeze, active, ld_use, raw_any, raw;
   function automatic logic hit(input logic wen, input logic [RW-1:0] dest, input logic [RW-1:0] src);
      return wen && dest != '0 && dest == src;
   endfunction
   always_comb begin
      // the cycle dhit arrives in MEMWAIT is the release cycle and runs normally
      freeze      = !dhit && (state_q == MEMWAIT || (state_q == RUN && mem_req));
      active      = state_q != HALT && !freeze;
      ld_use      = ex_memread && (hit(ex_wen, ex_dest, rs_id) || hit(ex_wen, ex_dest, rt_id));
      raw_any     = hit(ex_wen, ex_dest, rs_id) || hit(ex_wen, ex_dest, rt_id) ||
                    hit(mem_wen, mem_dest, rs_id) || hit(mem_wen, mem_dest, rt_id);
      raw         = ld_use || (!FWD_EN && raw_any);
      pipe_en     = !freeze;
      stall_pc    = state_q == HALT || (active && !br_mispred && (raw || !ihit));
      stall_ifid  = active && !br_mispred && raw;
      flush_ifid  = state_q == HALT || (active && (br_mispred || (!raw && !ihit)));
      flush_idex  = active && (br_mispred || raw);
      flush_exmem = active && br_mispred;
      fwdA        = !FWD_EN ? 2'b00 : hit(mem_wen, mem_dest, rs_ex) ? 2'b01 : hit(wb_wen, wb_dest, rs_ex) ? 2'b10 : 2'b00;
      fwdB        = !FWD_EN ? 2'b00 : hit(mem_wen, mem_dest, rt_ex) ? 2'b01 : hit(wb_wen, wb_dest, rt_ex) ? 2'b10 : 2'b00;
      state_d     = (state_q == HALT || (!freeze && halt_mem)) ? HALT : freeze ? MEMWAIT : RUN;
      stall_cnt_d = (state_q != HALT && (freeze || stall_pc) && !(&stall_cnt_q)) ? stall_cnt_q + ONE : stall_cnt_q;
      flush_cnt_d = (active && br_mispred && !(&flush_cnt_q)) ? flush_cnt_q + ONE : flush_cnt_q;
      stall_cnt   = stall_cnt_q;
      flush_cnt   = flush_cnt_q;
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
endmodule
